// File: rtl/decode_scoreboard.sv
// Issue gate between decode and execute: tracks in-flight register writers
// per destination and holds back instructions with RAW/WAW or budget hazards.
module decode_scoreboard #(
  parameter int AWIDTH       = 5,
  parameter int CWIDTH       = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int SWIDTH       = 16,
  localparam int NREG        = 1 << AWIDTH,
  localparam int IWIDTH      = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic              sb_clk,
  input  logic              sb_rst,
  input  logic              sb_i_valid,
  input  logic              sb_i_ready,
  input  logic              sb_i_use_rs,
  input  logic              sb_i_use_rt,
  input  logic [AWIDTH-1:0] sb_i_addr_rs,
  input  logic [AWIDTH-1:0] sb_i_addr_rt,
  input  logic              sb_i_wr_en,
  input  logic [AWIDTH-1:0] sb_i_addr_wr,
  input  logic              sb_i_wb_en,
  input  logic [AWIDTH-1:0] sb_i_wb_addr,
  output logic              sb_o_issue,
  output logic              sb_o_stall,
  output logic [NREG-1:0]   sb_o_pending,
  output logic [IWIDTH-1:0] sb_o_inflight,
  output logic [SWIDTH-1:0] sb_o_stall_cnt,
  output logic              sb_o_err
);

  localparam logic [IWIDTH-1:0] MAX_IF = IWIDTH'(MAX_INFLIGHT);

  logic [CWIDTH-1:0] cnt_arr [NREG];
  logic [NREG-1:0]   pending_reg;
  logic [IWIDTH-1:0] inflight_reg;
  logic [SWIDTH-1:0] stall_cnt_reg;
  logic              err_reg;

  logic hz_rs, hz_rt, wr_eff, waw, full;
  logic issue, stall, inc_wr;
  logic wb_nz, wb_hit, wb_spurious;

  // Hazards look only at registered counts; a writeback in the same cycle
  // does not bypass, which keeps issue free of any path through retirement.
  always_comb begin
    hz_rs       = sb_i_use_rs & (sb_i_addr_rs != '0) & (cnt_arr[sb_i_addr_rs] != '0);
    hz_rt       = sb_i_use_rt & (sb_i_addr_rt != '0) & (cnt_arr[sb_i_addr_rt] != '0);
    wr_eff      = sb_i_wr_en & (sb_i_addr_wr != '0);
    waw         = wr_eff & (cnt_arr[sb_i_addr_wr] == '1);
    full        = wr_eff & (inflight_reg == MAX_IF);
    issue       = ~sb_rst & sb_i_valid & sb_i_ready & ~hz_rs & ~hz_rt & ~waw & ~full;
    stall       = ~sb_rst & sb_i_valid & ~issue;
    inc_wr      = issue & wr_eff;
    wb_nz       = sb_i_wb_en & (sb_i_wb_addr != '0);
    wb_hit      = wb_nz & (cnt_arr[sb_i_wb_addr] != '0);
    wb_spurious = wb_nz & (cnt_arr[sb_i_wb_addr] == '0);
  end

  // Register 0 never moves: inc_wr and wb_hit both exclude address 0.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      logic [CWIDTH-1:0] cnt_reg;
      logic [CWIDTH-1:0] cnt_next;
      logic              up, dn;

      always_comb begin
        up = inc_wr & (sb_i_addr_wr == AWIDTH'(gi));
        dn = wb_hit & (sb_i_wb_addr == AWIDTH'(gi));
        cnt_next = cnt_reg;
        if (up && !dn)
          cnt_next = cnt_reg + 1'b1;
        else if (dn && !up)
          cnt_next = cnt_reg - 1'b1;
      end

      always_ff @(posedge sb_clk) begin
        if (sb_rst) begin
          cnt_reg         <= '0;
          pending_reg[gi] <= 1'b0;
        end else begin
          cnt_reg         <= cnt_next;
          pending_reg[gi] <= (cnt_next != '0);
        end
      end

      assign cnt_arr[gi] = cnt_reg;
    end
  endgenerate

  always_ff @(posedge sb_clk) begin
    if (sb_rst) begin
      inflight_reg  <= '0;
      stall_cnt_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      if (inc_wr && !wb_hit)
        inflight_reg <= inflight_reg + 1'b1;
      else if (wb_hit && !inc_wr)
        inflight_reg <= inflight_reg - 1'b1;
      if (stall && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (wb_spurious)
        err_reg <= 1'b1;
    end
  end

  assign sb_o_issue     = issue;
  assign sb_o_stall     = stall;
  assign sb_o_pending   = pending_reg;
  assign sb_o_inflight  = inflight_reg;
  assign sb_o_stall_cnt = stall_cnt_reg;
  assign sb_o_err       = err_reg;

endmodule
